pipe_stall_ctrl: RTL and testbench
==================================

PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1023: data-memory wait cycles before fault.
REQ-002 Parameter CNT_WIDTH, default 32: width of the performance counters.
REQ-003 clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 load_use_hazard  input  1  load-use stall request from hazard detection.
REQ-006 branch_taken  input  1  branch resolved taken in EX.
REQ-007 jump_taken  input  1  jump decoded in ID.
REQ-008 imem_ready  input  1  instruction memory returns a valid fetch this cycle.
REQ-009 dmem_req  input  1  MEM stage holds a valid load or store.
REQ-010 dmem_ready  input  1  data memory completes the access this cycle.
REQ-011 err_clr  input  1  software or debug clear of the fault state.
REQ-012 pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  output  1 each  per-stage register enables.
REQ-013 if_id_flush, id_ex_flush  output  1 each  bubble insertion into IF/ID and ID/EX.
REQ-014 state  output  2  registered controller state.
REQ-015 mem_timeout  output  1  sticky data-memory timeout flag.
REQ-016 stall_cycles  output  CNT_WIDTH  count of cycles with pc_en=0.
REQ-017 flush_events  output  CNT_WIDTH  count of cycles with if_id_flush=1.

Function
REQ-018 States: RUN=0, MEM_WAIT=1, IF_WAIT=2, FAULT=3.
REQ-019 Enables and flushes are combinational from the current inputs and the registered state, applied in same-cycle priority order FAULT > MEM freeze > branch > jump > load-use > IF wait > run.
REQ-020 FAULT state: all enables 0 and both flushes 0.
REQ-021 MEM freeze (dmem_req=1, dmem_ready=0): all enables 0 and both flushes 0; a simultaneous branch_taken or jump_taken is ignored and is reapplied later because EX and ID stay frozen.
REQ-022 branch_taken: all enables 1, if_id_flush=1, id_ex_flush=1.
REQ-023 jump_taken (no branch): all enables 1, if_id_flush=1, id_ex_flush=0.
REQ-024 load_use_hazard: pc_en=0, if_id_en=0, id_ex_flush=1; all other enables 1.
REQ-025 IF wait (imem_ready=0): pc_en=0, if_id_flush=1; all other enables 1.
REQ-026 Branch or jump with imem_ready=0: pc_en=1 so that the redirect target is captured.
REQ-027 Otherwise: all enables 1 and both flushes 0.
REQ-028 Next-state rule outside FAULT: MEM freeze condition goes to MEM_WAIT; else imem_ready=0 goes to IF_WAIT; else RUN.
REQ-029 A wait counter increments each cycle the MEM freeze condition holds.
REQ-030 The wait counter clears on any cycle the MEM freeze condition does not hold.
REQ-031 When the MEM freeze holds with wait counter = TIMEOUT_CYCLES-1, the next state is FAULT and mem_timeout is set.
REQ-032 dmem_ready=1 in the same cycle that timeout is reached means no fault.
REQ-033 FAULT is left only by err_clr=1, which goes to RUN next cycle and clears mem_timeout and the wait counter.
REQ-034 err_clr outside FAULT has no effect.
REQ-035 stall_cycles increments in any cycle with pc_en=0, excluding FAULT.
REQ-036 flush_events increments in any cycle with if_id_flush=1.
REQ-037 Both counters saturate at all-ones and never wrap.

Reset
REQ-038 rst_n low asynchronously forces state=RUN, wait counter=0, mem_timeout=0, stall_cycles=0 and flush_events=0.
REQ-039 During reset the combinational outputs follow the RUN-state rules from the current inputs.
REQ-040 Reset asserted in MEM_WAIT or FAULT abandons the operation with no residual flag.

Structure
REQ-041 The state enum and its encodings belong in RV32I_definitions.
REQ-042 The flush/enable priority is a single combinational block.
REQ-043 One sub-module, sat_counter (CNT_WIDTH, enable, async reset), is instantiated twice for the two performance counters.

Verification
REQ-044 Load-use: load_use_hazard=1 for one cycle -> pc_en=0, if_id_en=0, id_ex_flush=1 that cycle; stall_cycles goes 0->1.
REQ-045 Branch plus load-use in the same cycle -> if_id_flush=1, id_ex_flush=1, pc_en=1; flush_events goes to 1; stall_cycles stays 0.
REQ-046 dmem_req=1 with dmem_ready=0 for 5 cycles while branch_taken=1 -> all enables 0 and no flush for 5 cycles, state=MEM_WAIT; the cycle dmem_ready=1 gives the branch flush.
REQ-047 TIMEOUT_CYCLES=4 with dmem_ready held 0 -> state=FAULT and mem_timeout=1 after the 4th wait cycle; err_clr pulse -> state=RUN, mem_timeout=0.
REQ-048 CNT_WIDTH=4 with pc_en forced low for 20 cycles -> stall_cycles stops at 15.
REQ-049 rst_n dropped mid-MEM_WAIT -> state=0 and counters=0 immediately, with no clock edge required.

Source files
------------

// File: rtl/pipe_stall_ctrl_pkg.sv
// RV32I_definitions: shared pipeline-control types for the stall/flush controller.
package RV32I_definitions;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        IF_WAIT  = 2'd2,
        FAULT    = 2'd3
    } stall_state_t;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: enable-driven up counter that holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (en && !(&count))
            count <= count + W'(1);
    end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: five-stage pipeline enable/flush priority logic with data-memory timeout fault.
module pipe_stall_ctrl
    import RV32I_definitions::*;
#(
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_use_hazard,
    input  logic                 branch_taken,
    input  logic                 jump_taken,
    input  logic                 imem_ready,
    input  logic                 dmem_req,
    input  logic                 dmem_ready,
    input  logic                 err_clr,
    output logic                 pc_en,
    output logic                 if_id_en,
    output logic                 id_ex_en,
    output logic                 ex_mem_en,
    output logic                 mem_wb_en,
    output logic                 if_id_flush,
    output logic                 id_ex_flush,
    output logic [1:0]           state,
    output logic                 mem_timeout,
    output logic [CNT_WIDTH-1:0] stall_cycles,
    output logic [CNT_WIDTH-1:0] flush_events
);

    localparam int WW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WW-1:0] WAIT_MAX = WW'(TIMEOUT_CYCLES - 1);

    stall_state_t  st;
    logic [WW-1:0] wait_cnt;
    logic          mem_freeze;

    assign mem_freeze = dmem_req && !dmem_ready;
    assign state      = st;

    // Branch/jump sit above IF wait so pc_en stays high and the redirect target is captured.
    always_comb begin
        {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b11111;
        {if_id_flush, id_ex_flush} = 2'b00;
        if (st == FAULT || mem_freeze)
            {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b00000;
        else if (branch_taken)
            {if_id_flush, id_ex_flush} = 2'b11;
        else if (jump_taken)
            if_id_flush = 1'b1;
        else if (load_use_hazard)
            {pc_en, if_id_en, id_ex_flush} = 3'b001;
        else if (!imem_ready)
            {pc_en, if_id_flush} = 2'b01;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st          <= RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else if (st == FAULT) begin
            if (err_clr) begin
                st          <= RUN;
                wait_cnt    <= '0;
                mem_timeout <= 1'b0;
            end
        end else if (mem_freeze) begin
            st          <= wait_cnt == WAIT_MAX ? FAULT : MEM_WAIT;
            mem_timeout <= wait_cnt == WAIT_MAX;
            wait_cnt    <= wait_cnt == WAIT_MAX ? '0 : wait_cnt + WW'(1);
        end else begin
            st       <= imem_ready ? RUN : IF_WAIT;
            wait_cnt <= '0;
        end
    end

    sat_counter #(.W(CNT_WIDTH)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (!pc_en && st != FAULT),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_WIDTH)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (if_id_flush),
        .count (flush_events)
    );

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: directed checks of stall/flush priority, timeout fault, counters and reset.
module tb_pipe_stall_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic load_use_hazard = 1'b0, branch_taken = 1'b0, jump_taken = 1'b0;
    logic imem_ready = 1'b1, dmem_req = 1'b0, dmem_ready = 1'b0, err_clr = 1'b0;

    logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush;
    logic [1:0]  state;
    logic        mem_timeout;
    logic [31:0] stall_cycles, flush_events;

    logic        t_pc_en, t_if_id_en, t_id_ex_en, t_ex_mem_en, t_mem_wb_en, t_if_id_flush, t_id_ex_flush;
    logic [1:0]  t_state;
    logic        t_mem_timeout;
    logic [3:0]  t_stall_cycles, t_flush_events;

    logic [6:0] ctrl, t_ctrl;
    assign ctrl   = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush};
    assign t_ctrl = {t_pc_en, t_if_id_en, t_id_ex_en, t_ex_mem_en, t_mem_wb_en, t_if_id_flush, t_id_ex_flush};

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pipe_stall_ctrl dut (
        .clk(clk), .rst_n(rst_n), .load_use_hazard(load_use_hazard), .branch_taken(branch_taken),
        .jump_taken(jump_taken), .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .err_clr(err_clr), .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
        .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .state(state),
        .mem_timeout(mem_timeout), .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    pipe_stall_ctrl #(.TIMEOUT_CYCLES(4), .CNT_WIDTH(4)) dut_t (
        .clk(clk), .rst_n(rst_n), .load_use_hazard(load_use_hazard), .branch_taken(branch_taken),
        .jump_taken(jump_taken), .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .err_clr(err_clr), .pc_en(t_pc_en), .if_id_en(t_if_id_en), .id_ex_en(t_id_ex_en),
        .ex_mem_en(t_ex_mem_en), .mem_wb_en(t_mem_wb_en), .if_id_flush(t_if_id_flush),
        .id_ex_flush(t_id_ex_flush), .state(t_state), .mem_timeout(t_mem_timeout),
        .stall_cycles(t_stall_cycles), .flush_events(t_flush_events)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset: registered state cleared, outputs follow RUN rules from inputs
        #1;
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_stall", 64'(stall_cycles), 64'd0);
        chk("rst_flush", 64'(flush_events), 64'd0);
        chk("rst_tmo", 64'(mem_timeout), 64'd0);
        chk("rst_ctrl_idle", 64'(ctrl), 64'b1111100);
        load_use_hazard = 1'b1;
        #1 chk("rst_ctrl_lu", 64'(ctrl), 64'b0011101);
        load_use_hazard = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // load-use stall
        load_use_hazard = 1'b1;
        #1 chk("lu_ctrl", 64'(ctrl), 64'b0011101);
        tick();
        load_use_hazard = 1'b0;
        chk("lu_stall", 64'(stall_cycles), 64'd1);
        chk("lu_flush", 64'(flush_events), 64'd0);

        // branch outranks load-use
        branch_taken = 1'b1; load_use_hazard = 1'b1;
        #1 chk("br_lu_ctrl", 64'(ctrl), 64'b1111111);
        tick();
        branch_taken = 1'b0; load_use_hazard = 1'b0;
        chk("br_lu_flush", 64'(flush_events), 64'd1);
        chk("br_lu_stall", 64'(stall_cycles), 64'd1);

        // jump
        jump_taken = 1'b1;
        #1 chk("jmp_ctrl", 64'(ctrl), 64'b1111110);
        tick();
        jump_taken = 1'b0;
        chk("jmp_flush", 64'(flush_events), 64'd2);

        // instruction fetch wait
        imem_ready = 1'b0;
        #1 chk("ifw_ctrl", 64'(ctrl), 64'b0111110);
        tick();
        chk("ifw_state", 64'(state), 64'd2);
        chk("ifw_stall", 64'(stall_cycles), 64'd2);
        chk("ifw_flush", 64'(flush_events), 64'd3);
        branch_taken = 1'b1;
        #1 chk("ifw_br_ctrl", 64'(ctrl), 64'b1111111);
        tick();
        branch_taken = 1'b0;
        chk("ifw_br_stall", 64'(stall_cycles), 64'd2);
        chk("ifw_br_flush", 64'(flush_events), 64'd4);
        imem_ready = 1'b1;
        tick();
        chk("ifw_exit_state", 64'(state), 64'd0);

        // memory freeze masks a pending branch for 5 cycles
        dmem_req = 1'b1; dmem_ready = 1'b0; branch_taken = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1 chk("mf_ctrl", 64'(ctrl), 64'b0000000);
            tick();
            chk("mf_state", 64'(state), 64'd1);
        end
        chk("mf_stall", 64'(stall_cycles), 64'd7);
        chk("mf_flush", 64'(flush_events), 64'd4);
        chk("t_fault_state", 64'(t_state), 64'd3);
        chk("t_fault_tmo", 64'(t_mem_timeout), 64'd1);
        chk("mf_tmo", 64'(mem_timeout), 64'd0);
        dmem_ready = 1'b1;
        #1 chk("mf_rel_ctrl", 64'(ctrl), 64'b1111111);
        chk("t_fault_ctrl", 64'(t_ctrl), 64'b0000000);
        tick();
        chk("mf_rel_state", 64'(state), 64'd0);
        chk("mf_rel_flush", 64'(flush_events), 64'd5);
        chk("t_fault_hold", 64'(t_state), 64'd3);
        dmem_req = 1'b0; dmem_ready = 1'b0; branch_taken = 1'b0;

        // err_clr leaves FAULT; no effect on the RUN instance
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("clr_t_state", 64'(t_state), 64'd0);
        chk("clr_t_tmo", 64'(t_mem_timeout), 64'd0);
        chk("clr_run_state", 64'(state), 64'd0);

        // clean timeout: fault after the 4th wait cycle
        dmem_req = 1'b1;
        repeat (3) tick();
        chk("to3_state", 64'(t_state), 64'd1);
        chk("to3_tmo", 64'(t_mem_timeout), 64'd0);
        tick();
        chk("to4_state", 64'(t_state), 64'd3);
        chk("to4_tmo", 64'(t_mem_timeout), 64'd1);
        dmem_req = 1'b0; err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("to_clr_state", 64'(t_state), 64'd0);

        // ready on the timeout cycle avoids the fault
        dmem_req = 1'b1;
        repeat (3) tick();
        dmem_ready = 1'b1;
        tick();
        dmem_req = 1'b0; dmem_ready = 1'b0;
        chk("late_ready_state", 64'(t_state), 64'd0);
        chk("late_ready_tmo", 64'(t_mem_timeout), 64'd0);

        // asynchronous reset in MEM_WAIT
        dmem_req = 1'b1;
        repeat (2) tick();
        chk("ar_pre_state", 64'(state), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_state", 64'(state), 64'd0);
        chk("ar_stall", 64'(stall_cycles), 64'd0);
        chk("ar_flush", 64'(flush_events), 64'd0);
        chk("ar_t_stall", 64'(t_stall_cycles), 64'd0);
        dmem_req = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // stall counter saturation
        imem_ready = 1'b0;
        repeat (20) tick();
        imem_ready = 1'b1;
        chk("sat_t_stall", 64'(t_stall_cycles), 64'd15);
        chk("sat_stall", 64'(stall_cycles), 64'd20);
        chk("sat_t_flush", 64'(t_flush_events), 64'd15);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
